// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants, rx state encoding and baud-divider value.
package uart_pkg;
  localparam int DATA_BITS_DEF = 8;
  localparam int OVERSAMPLE_DEF = 16;
  localparam int CLK_HZ = 50_000_000;
  localparam int BAUD = 115_200;
  // Terminal count for the Counter stage that produces the oversample Enable tick.
  localparam int BAUD_DIV = CLK_HZ / (BAUD * OVERSAMPLE_DEF);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} rx_state_t;
endpackage

// File: rtl/sync2.sv
// sync2: two-flop synchronizer with selectable reset value.
module sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic s1;
  always_ff @(posedge clk)
    if (rst) {q, s1} <= {2{RST_VAL}};
    else {q, s1} <= {s1, d};
endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampled UART receiver with sticky framing and overrun flags.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS = DATA_BITS_DEF,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 Enable,
  input  logic                 RxIn,
  input  logic                 RxRead,
  output logic [DATA_BITS-1:0] RxData,
  output logic                 RxReady,
  output logic                 FramingError,
  output logic                 Overrun
);
  localparam int CW = $clog2(OVERSAMPLE);
  localparam int IW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] HALF = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(OVERSAMPLE - 1);
  localparam logic [IW-1:0] LAST_BIT = IW'(DATA_BITS - 1);
  rx_state_t state;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic [DATA_BITS-1:0] sh;
  logic line, stop_tick, done, bad_stop;
  sync2 #(.RST_VAL(1'b1)) u_sync (.clk(Clock), .rst(Reset), .d(RxIn), .q(line));
  assign stop_tick = Enable && state == STOP && cnt == FULL;
  assign done = stop_tick && line;
  assign bad_stop = stop_tick && !line;
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      sh <= '0;
    end else if (Enable) begin
      case (state)
        IDLE: if (!line) begin
          state <= START;
          cnt <= '0;
        end
        START: if (cnt == HALF) begin
          state <= line ? IDLE : DATA;
          cnt <= '0;
          idx <= '0;
        end else cnt <= cnt + 1'b1;
        DATA: if (cnt == FULL) begin
          sh <= {line, sh[DATA_BITS-1:1]};
          cnt <= '0;
          idx <= idx + 1'b1;
          if (idx == LAST_BIT) state <= STOP;
        end else cnt <= cnt + 1'b1;
        STOP: if (cnt == FULL) begin
          state <= line ? IDLE : WAIT_HIGH;
          cnt <= '0;
        end else cnt <= cnt + 1'b1;
        WAIT_HIGH: if (line) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  // Later assignments win: a completion overrides the read-clear of RxReady.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      RxData <= '0;
      RxReady <= 1'b0;
      FramingError <= 1'b0;
      Overrun <= 1'b0;
    end else begin
      if (RxRead) {RxReady, FramingError, Overrun} <= 3'b000;
      if (done && (!RxReady || RxRead)) begin
        RxData <= sh;
        RxReady <= 1'b1;
      end
      if (done && RxReady && !RxRead) Overrun <= 1'b1;
      if (bad_stop) FramingError <= 1'b1;
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed scoreboard bench for uart_rx.
module tb_uart_rx;
  import uart_pkg::*;
  logic clk = 1'b0, rst = 1'b1, en = 1'b1, rx = 1'b1, rd = 1'b0;
  logic [7:0] rx_data;
  logic rdy, ferr, ovr;
  int total = 0, bad = 0, en_gap = 1, ec = 0, lat = 0;
  logic [7:0] sb[$];

  uart_rx dut (
    .Clock(clk), .Reset(rst), .Enable(en), .RxIn(rx), .RxRead(rd),
    .RxData(rx_data), .RxReady(rdy), .FramingError(ferr), .Overrun(ovr)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    #2;
    ec = (ec + 1) % en_gap;
    en = (ec == 0);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic hold_ticks(input int n);
    int k = 0;
    while (k < n) begin
      @(posedge clk);
      if (en) k++;
    end
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_v, input int stop_ticks);
    @(posedge clk);
    #1 rx = 1'b0;
    hold_ticks(16);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      hold_ticks(16);
    end
    rx = stop_v;
    hold_ticks(stop_ticks);
  endtask

  task automatic pulse_read();
    rd = 1'b1;
    @(posedge clk);
    #1 rd = 1'b0;
  endtask

  task automatic expect_byte(input string tag);
    bit ok = rdy;
    for (int k = 0; k < 3000 && !ok; k++) begin
      @(posedge clk);
      #1 ok = rdy;
    end
    chk({tag, "_rdy"}, 32'(ok), 1);
    chk({tag, "_sb"}, 32'(sb.size() != 0), 1);
    if (sb.size() != 0) chk(tag, rx_data, sb.pop_front());
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_data", rx_data, 0);
    chk("rst_rdy", rdy, 0);
    chk("rst_ferr", ferr, 0);
    chk("rst_ovr", ovr, 0);

    // first frame, also measures start-to-ready latency
    sb.push_back(8'h55);
    fork
      send_frame(8'h55, 1'b1, 16);
      begin
        @(posedge clk);
        #1;
        for (int k = 0; k < 300; k++) begin
          @(posedge clk);
          #1 lat++;
          if (rdy) break;
        end
      end
    join
    chk($sformatf("latency_%0d", lat), 32'(lat >= 153 && lat <= 155), 1);
    expect_byte("f55");
    chk("f55_ferr", ferr, 0);
    chk("f55_ovr", ovr, 0);
    pulse_read();
    chk("f55_read_rdy", rdy, 0);

    // short low glitch is rejected
    @(posedge clk);
    #1 rx = 1'b0;
    hold_ticks(4);
    rx = 1'b1;
    hold_ticks(30);
    chk("glitch_state", dut.state, IDLE);
    chk("glitch_rdy", rdy, 0);
    chk("glitch_data", rx_data, 8'h55);

    // framing error with line held low
    send_frame(8'hA3, 1'b0, 40);
    chk("fe_flag", ferr, 1);
    chk("fe_rdy", rdy, 0);
    chk("fe_wait_state", dut.state, WAIT_HIGH);
    chk("fe_data", rx_data, 8'h55);
    rx = 1'b1;
    hold_ticks(4);
    chk("fe_idle_state", dut.state, IDLE);
    sb.push_back(8'h3C);
    send_frame(8'h3C, 1'b1, 16);
    expect_byte("fe_next");
    chk("fe_sticky", ferr, 1);
    pulse_read();
    chk("fe_clr_ferr", ferr, 0);
    chk("fe_clr_rdy", rdy, 0);

    // overrun: second byte dropped
    sb.push_back(8'h11);
    send_frame(8'h11, 1'b1, 16);
    send_frame(8'h22, 1'b1, 16);
    expect_byte("ovr_keep");
    chk("ovr_flag", ovr, 1);
    pulse_read();
    chk("ovr_clr_rdy", rdy, 0);
    chk("ovr_clr_ovr", ovr, 0);
    chk("ovr_clr_ferr", ferr, 0);

    // read coinciding with a completion loads the new byte
    sb.push_back(8'h66);
    send_frame(8'h66, 1'b1, 16);
    expect_byte("co_first");
    sb.push_back(8'h99);
    fork
      send_frame(8'h99, 1'b1, 16);
      begin
        @(posedge clk);
        #1;
        repeat (lat - 1) @(posedge clk);
        #1 rd = 1'b1;
        @(posedge clk);
        #1 rd = 1'b0;
      end
    join
    expect_byte("co_second");
    chk("co_ovr", ovr, 0);

    // reset during bit 4 of 0xF0
    @(posedge clk);
    #1 rx = 1'b0;
    hold_ticks(16);
    for (int i = 0; i < 4; i++) begin
      rx = (i >= 4);
      hold_ticks(16);
    end
    rx = 1'b1;
    hold_ticks(8);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("mid_rst_data", rx_data, 0);
    chk("mid_rst_rdy", rdy, 0);
    chk("mid_rst_ovr", ovr, 0);
    chk("mid_rst_ferr", ferr, 0);
    chk("mid_rst_state", dut.state, IDLE);
    hold_ticks(40);
    sb.push_back(8'hC3);
    send_frame(8'hC3, 1'b1, 16);
    expect_byte("after_rst");
    pulse_read();

    // loopback from a bench transmitter at a slower Enable rate
    en_gap = 4;
    hold_ticks(4);
    fork
      begin
        logic [7:0] lb[4] = '{8'h00, 8'hFF, 8'h5A, 8'h81};
        for (int i = 0; i < 4; i++) begin
          sb.push_back(lb[i]);
          send_frame(lb[i], 1'b1, 16);
        end
      end
      begin
        for (int i = 0; i < 4; i++) begin
          #1;
          expect_byte($sformatf("loop%0d", i));
          pulse_read();
        end
      end
    join
    chk("loop_ferr", ferr, 0);
    chk("loop_ovr", ovr, 0);
    chk("loop_sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
